// File: rtl/g_macro_pkg.sv
// Shared types and sizes for the g_4sipo serial-to-parallel converter.
// G_4SIPO_PARITY_EN adds a fifth, odd-parity bit to every frame.
package g_macro_pkg;

    localparam int WORD_W = 4;
`ifdef G_4SIPO_PARITY_EN
    localparam int N_BITS = 5;
`else
    localparam int N_BITS = 4;
`endif
    localparam int CNT_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Indices at or beyond WORD_W (the parity slot) leave the word untouched.
    function automatic logic [WORD_W-1:0] place_bit(
        input logic [WORD_W-1:0] word,
        input logic [CNT_W-1:0]  idx,
        input logic              b,
        input logic              msb_first
    );
        logic [WORD_W-1:0] r;
        int                target;
        r      = word;
        target = msb_first ? (WORD_W - 1 - int'(idx)) : int'(idx);
        for (int i = 0; i < WORD_W; i++) begin
            if (i == target) r[i] = b;
        end
        return r;
    endfunction

endpackage

// File: rtl/g_4nor.sv
// 4-input NOR: high only when every input bit is zero.
module g_4nor (
    input  logic [3:0] a,
    output logic       zn
);

    assign zn = ~|a;

endmodule

// File: rtl/g_4sipo.sv
// Framed 4-bit serial-in/parallel-out register with zero detect.
// Define G_4SIPO_PARITY_EN to take an odd-parity fifth bit and drive PERR.
//
// state | meaning
// IDLE  | no frame in progress, waiting for SYNC
// SHIFT | collecting bits of a frame, CNT = next bit index
module g_4sipo
    import g_macro_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CE,
    input  logic              SYNC,
    input  logic              SI,
    output logic [WORD_W-1:0] Q,
    output logic              VALID,
    output logic              ZN,
    output logic              PERR
);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] sr;
    logic [WORD_W-1:0] sr_load;
    logic              zn_load;
    logic              last;
    logic              restart;

    // SYNC on the final bit still completes the frame rather than restarting it.
    assign last    = (state == SHIFT) && (cnt == CNT_W'(N_BITS - 1));
    assign restart = SYNC && !last;
    assign sr_load = place_bit(restart ? '0 : sr, restart ? '0 : cnt, SI, MSB_FIRST);

    g_4nor u_nor (
        .a  (sr_load),
        .zn (zn_load)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
            Q     <= '0;
            VALID <= 1'b0;
            ZN    <= 1'b1;
        end else begin
            VALID <= 1'b0;
            if (CE) begin
                case (state)
                    IDLE: begin
                        if (SYNC) begin
                            sr    <= sr_load;
                            cnt   <= CNT_W'(1);
                            state <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (last) begin
                            Q     <= sr_load;
                            ZN    <= zn_load;
                            VALID <= 1'b1;
                            sr    <= '0;
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            sr  <= sr_load;
                            cnt <= restart ? CNT_W'(1) : cnt + CNT_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef G_4SIPO_PARITY_EN
    logic par;

    // Running XOR of the frame; odd parity means the full 5-bit XOR must be 1.
    always_ff @(posedge CLK) begin
        if (RST) begin
            par  <= 1'b0;
            PERR <= 1'b0;
        end else begin
            PERR <= 1'b0;
            if (CE) begin
                if (last) begin
                    PERR <= ~(par ^ SI);
                    par  <= 1'b0;
                end else if (state == SHIFT || SYNC) begin
                    par <= restart ? SI : (par ^ SI);
                end
            end
        end
    end
`else
    assign PERR = 1'b0;
`endif

endmodule
